multi_port_reg_file: RTL and testbench

Parametrised register file: DEPTH words of WIDTH bits, one synchronous write port and NUM_RD combinational read ports. A hard-wired zero register and optional write-to-read bypass are included. It is the successor to the fixed 64-bit single-register generator and is the datapath register file for the 64-bit CPU core. Storage is built from per-word enabled, resettable registers.

---
 rtl/cpu_pkg.sv | 8 +
 rtl/reg_word.sv | 14 +
 rtl/multi_port_reg_file.sv | 36 +++
 tb/tb_multi_port_reg_file.sv | 116 +++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared register-file sizing and word/index types for the 64-bit core
package cpu_pkg;
    localparam int REG_WIDTH = 64;
    localparam int REG_DEPTH = 32;
    localparam int ZERO_IDX  = 31;
    typedef logic [63:0] reg_word_t;
    typedef logic [4:0]  reg_idx_t;
endpackage

// File: rtl/reg_word.sv
// reg_word: WIDTH-bit enabled register with synchronous active-high clear
module reg_word #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk)
        if (reset) q <= '0;
        else if (en) q <= d;
endmodule

// File: rtl/multi_port_reg_file.sv
// multi_port_reg_file: DEPTH x WIDTH register file, one write port, NUM_RD combinational reads
import cpu_pkg::*;
module multi_port_reg_file #(
    parameter int WIDTH    = REG_WIDTH,
    parameter int DEPTH    = REG_DEPTH,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = ZERO_IDX,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_addr,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic [NUM_RD*AW-1:0]    rd_addr,
    output logic [NUM_RD*WIDTH-1:0] rd_data
);
    logic [DEPTH-1:0][WIDTH-1:0] mem;
    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        reg_word #(.WIDTH(WIDTH)) u_word (
            .clk(clk),
            .reset(reset),
            .en(wr_en && wr_addr == AW'(i) && i != ZERO_REG),
            .d(wr_data),
            .q(mem[i])
        );
    end
    // zero register beats bypass; bypass is suppressed while reset is held
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [AW-1:0] ra;
        assign ra = rd_addr[p*AW +: AW];
        assign rd_data[p*WIDTH +: WIDTH] = (int'(ra) == ZERO_REG) ? '0 :
            (BYPASS != 0 && !reset && wr_en && wr_addr == ra) ? wr_data : mem[ra];
    end
endmodule

// File: tb/tb_multi_port_reg_file.sv
// tb_multi_port_reg_file: directed scoreboard bench for bypass and non-bypass builds
module tb_multi_port_reg_file;
    logic         clk = 0;
    logic         reset;
    logic         wr_en;
    logic [4:0]   wr_addr;
    logic [63:0]  wr_data;
    logic [9:0]   rd_addr;
    logic [127:0] rd_byp, rd_nob;
    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int          cyc;
        bit          dut;
        bit          port;
        logic [63:0] exp;
    } entry_t;
    entry_t sb[$];

    multi_port_reg_file #(.BYPASS(1)) dut_byp (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_byp)
    );
    multi_port_reg_file #(.BYPASS(0)) dut_nob (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_nob)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : mon
        entry_t e;
        logic [63:0] act;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            act = e.dut ? (e.port ? rd_nob[127:64] : rd_nob[63:0])
                        : (e.port ? rd_byp[127:64] : rd_byp[63:0]);
            n_cmp++;
            if (e.cyc != cyc || act !== e.exp) begin
                n_bad++;
                $display("FAIL %s port%0d cyc%0d: got %h expected %h",
                         e.dut ? "nobypass" : "bypass", e.port, e.cyc, act, e.exp);
            end
        end
    end

    function automatic void push(input logic [63:0] b0, b1, n0, n1);
        sb.push_back('{cyc, 1'b0, 1'b0, b0});
        sb.push_back('{cyc, 1'b0, 1'b1, b1});
        sb.push_back('{cyc, 1'b1, 1'b0, n0});
        sb.push_back('{cyc, 1'b1, 1'b1, n1});
    endfunction

    task automatic step(input logic r, we, input logic [4:0] wa, input logic [63:0] wd,
                        input logic [4:0] a0, a1, input logic [63:0] b0, b1, n0, n1);
        reset = r; wr_en = we; wr_addr = wa; wr_data = wd; rd_addr = {a1, a0};
        push(b0, b1, n0, n1);
        @(posedge clk); #1;
    endtask

    function automatic logic [63:0] swept(input int i);
        return (i == 31) ? 64'd0 : 64'(i * 3);
    endfunction

    localparam logic [63:0] DB = 64'hDEAD_BEEF_0000_0001;

    initial begin
        reset = 1; wr_en = 0; wr_addr = 0; wr_data = 0; rd_addr = 0;
        @(posedge clk); #1;
        for (int i = 0; i < 32; i++)
            step(0, 0, 0, 0, 5'(i), 5'(31 - i), 0, 0, 0, 0);
        // basic write, bypass vs delayed visibility
        step(0, 1, 5, DB, 5, 6, DB, 0, 0, 0);
        step(0, 0, 0, 0, 5, 6, DB, 0, DB, 0);
        step(0, 1, 3, 64'd550, 0, 3, 0, 64'd550, 0, 0);
        step(0, 0, 0, 0, 3, 3, 64'd550, 64'd550, 64'd550, 64'd550);
        // zero register ignores writes and is never forwarded
        step(0, 1, 31, 64'd420, 31, 31, 0, 0, 0, 0);
        step(0, 0, 0, 0, 31, 31, 0, 0, 0, 0);
        // reset dominates a coincident write; bypass suppressed during reset
        step(0, 1, 7, 64'd69, 7, 5, 64'd69, DB, 0, DB);
        step(1, 1, 7, 64'd215687, 7, 5, 64'd69, DB, 64'd69, DB);
        step(0, 0, 0, 0, 7, 5, 0, 0, 0, 0);
        step(0, 1, 7, 64'd1, 7, 3, 64'd1, 0, 0, 0);
        step(0, 0, 0, 0, 7, 3, 64'd1, 0, 64'd1, 0);
        // back-to-back writes to one address
        step(0, 1, 9, 64'd10, 9, 9, 64'd10, 64'd10, 0, 0);
        step(0, 1, 9, 64'd11, 9, 9, 64'd11, 64'd11, 64'd10, 64'd10);
        step(0, 0, 0, 0, 9, 9, 64'd11, 64'd11, 64'd11, 64'd11);
        // fill every writable word, then sweep and confirm values hold
        for (int i = 0; i < 31; i++)
            step(0, 1, 5'(i), 64'(i * 3), 31, 31, 0, 0, 0, 0);
        for (int i = 0; i < 32; i++)
            step(0, 0, 0, 0, 5'(i), 5'(31 - i), swept(i), swept(31 - i), swept(i), swept(31 - i));
        for (int k = 0; k < 10; k++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 32; i += 5)
            step(0, 0, 0, 0, 5'(i), 5'(i), swept(i), swept(i), swept(i), swept(i));
        @(negedge clk); @(posedge clk); #1;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1);
    end
endmodule
